// File: rtl/aes_key_expansion.sv
// aes_key_expansion: iterative AES-128 key schedule.
// A start pulse captures the cipher key. One round key is then produced per
// clock into an 11-entry register file. That register file is exposed through
// a registered random-access read port, and each new key is also streamed out.
// Optional feature macro: AES_KEYEXP_LAST_KEY_EN adds the last_round_key output
// (rk[10] while key_ready, else 0).
module aes_key_expansion #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [KW-1:0] cipher_key,
  input  logic          key_new_en,
  output logic          key_busy,
  output logic          key_ready,
  output logic          rk_valid,
  output logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_stream,
  input  logic [3:0]    rk_rd_idx,
  output logic [KW-1:0] rk_rd_data
`ifdef AES_KEYEXP_LAST_KEY_EN
  ,
  output logic [KW-1:0] last_round_key
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [KW-1:0] rk [0:NR];

  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   t, n0, n1, n2, n3;
  logic [KW-1:0] next_key;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, so 0 maps to 0) then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant for round keys 1..10
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key from the previous one; rk_stream always holds rk[cnt-1] in EXPAND
  always_comb begin
    w0 = rk_stream[127:96];
    w1 = rk_stream[95:64];
    w2 = rk_stream[63:32];
    w3 = rk_stream[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^
         {rcon(cnt), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Control FSM, round-key register file and streaming outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      key_busy  <= 1'b0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      rk_idx    <= 4'd0;
      rk_stream <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      rk_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (key_new_en) begin
            rk[0]     <= cipher_key;
            rk_valid  <= 1'b1;
            rk_idx    <= 4'd0;
            rk_stream <= cipher_key;
            cnt       <= 4'd1;
            key_ready <= 1'b0;
            key_busy  <= 1'b1;
            state     <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          // Starts are ignored here; the cycle after rk[NR] is written closes the run
          if (cnt == 4'(NR + 1)) begin
            state     <= ST_DONE;
            key_busy  <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            rk[cnt]   <= next_key;
            rk_valid  <= 1'b1;
            rk_idx    <= cnt;
            rk_stream <= next_key;
            cnt       <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered random-access read; out-of-range indices return 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_rd_data <= '0;
    end else if (rk_rd_idx <= 4'(NR)) begin
      rk_rd_data <= rk[rk_rd_idx];
    end else begin
      rk_rd_data <= '0;
    end
  end

`ifdef AES_KEYEXP_LAST_KEY_EN
  assign last_round_key = key_ready ? rk[NR] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Testbench for aes_key_expansion.
// It runs a FIPS-197 vector table, corner-case sequences and random keys.
// Every result is checked against a word-oriented key-schedule model. That
// model derives the S-box from exp/log tables.
// Optional feature macro checked when defined: AES_KEYEXP_LAST_KEY_EN.
`timescale 1ns/1ps
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [127:0] cipher_key = '0;
  logic         key_new_en = 1'b0;
  logic         key_busy, key_ready, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_stream;
  logic [3:0]   rk_rd_idx = 4'd0;
  logic [127:0] rk_rd_data;
`ifdef AES_KEYEXP_LAST_KEY_EN
  logic [127:0] last_round_key;
`endif

  aes_key_expansion dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cipher_key (cipher_key),
    .key_new_en (key_new_en),
    .key_busy   (key_busy),
    .key_ready  (key_ready),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk_stream  (rk_stream),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
`ifdef AES_KEYEXP_LAST_KEY_EN
    ,
    .last_round_key (last_round_key)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   exp_t [0:255];
  logic [7:0]   log_t [0:255];
  logic [127:0] m_rk  [0:10];
  logic [127:0] cap   [0:10];
  logic [127:0] tb_rk10 = '0;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] expv;
  } vec_t;
  vec_t vecs [6];

  localparam logic [127:0] K_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_A5 = {16{8'ha5}};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // exp/log tables over generator 3
  function automatic void init_tables();
    logic [7:0] e;
    e = 8'h01;
    log_t[0] = 8'h00;
    exp_t[255] = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = 8'(i);
      e = e ^ xt(e);
    end
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] b, s, c;
    c = 8'h63;
    b = (x == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return s;
  endfunction

  // FIPS-197 word-array key expansion into m_rk[0..10]
  function automatic void model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0]), sbox_ref(tmp[31:24])}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  task automatic rd(input logic [3:0] idx, output logic [127:0] d);
    @(negedge clk);
    rk_rd_idx = idx;
    @(negedge clk);
    d = rk_rd_data;
  endtask

  // Full expansion with stream/latency checks; optional ignored start at step inject_at
  task automatic run_expansion(input logic [127:0] key, input int inject_at);
    model_expand(key);
    @(negedge clk);
    cipher_key = key;
    key_new_en = 1'b1;
    rk_rd_idx  = 4'd10;
    @(negedge clk);
    key_new_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      chk("rk_valid", 128'(rk_valid), 128'(1));
      chk("rk_idx", 128'(rk_idx), 128'(i));
      chk("rk_stream", rk_stream, m_rk[i]);
      chk("key_ready_low", 128'(key_ready), 128'(0));
      chk("key_busy_high", 128'(key_busy), 128'(1));
      chk("rd_old_rk10", rk_rd_data, tb_rk10);
`ifdef AES_KEYEXP_LAST_KEY_EN
      chk("last_key_zero", last_round_key, 128'(0));
`endif
      cap[i] = rk_stream;
      if (i == inject_at) begin
        cipher_key = K_A5;
        key_new_en = 1'b1;
      end else begin
        key_new_en = 1'b0;
      end
      @(negedge clk);
    end
    key_new_en = 1'b0;
    chk("key_ready_rise", 128'(key_ready), 128'(1));
    chk("key_busy_fall", 128'(key_busy), 128'(0));
    chk("rk_valid_end", 128'(rk_valid), 128'(0));
    chk("rd_new_rk10", rk_rd_data, m_rk[10]);
`ifdef AES_KEYEXP_LAST_KEY_EN
    chk("last_key", last_round_key, m_rk[10]);
`endif
    tb_rk10 = m_rk[10];
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] rkey;
    logic [3:0]   ridx;

    init_tables();
    vecs[0] = '{K_A, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[1] = '{K_A, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{K_B, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{K_B, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{128'h0, 4'd1, 128'h62636363626363636263636362636363};
    vecs[5] = '{128'h0, 4'd15, 128'h0};

    // reset state
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_key_busy", 128'(key_busy), 128'(0));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_rk_stream", rk_stream, 128'(0));
    chk("rst_rd_data", rk_rd_data, 128'(0));
    reset_n = 1'b1;

    // FIPS-197 / all-zero vector table
    foreach (vecs[v]) begin
      run_expansion(vecs[v].key, -1);
      rd(vecs[v].idx, d);
      chk($sformatf("vec%0d_rd", v), d, vecs[v].expv);
    end

    // streamed keys must match register-file contents
    run_expansion(K_B, -1);
    for (int i = 0; i < 11; i++) begin
      rd(4'(i), d);
      chk($sformatf("stream_vs_rd%0d", i), d, cap[i]);
    end

    // start during EXPAND ignored, then restart from DONE
    run_expansion(K_A, 4);
    rd(4'd10, d);
    chk("ignored_start_rk10", d, 128'h13111d7fe3944a17f307a78b4d2b30c5);
`ifdef AES_KEYEXP_LAST_KEY_EN
    chk("last_key_fips", last_round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
`endif
    run_expansion(K_A5, -1);
    rd(4'd5, d);
    chk("restart_rk5", d, m_rk[5]);

    // random keys
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_expansion(rkey, -1);
      ridx = 4'($urandom_range(0, 15));
      rd(ridx, d);
      chk($sformatf("rand%0d_rd%0d", n, ridx), d, (ridx <= 4'd10) ? m_rk[ridx] : 128'h0);
    end

    // asynchronous reset in the middle of an expansion
    model_expand(K_B);
    @(negedge clk);
    cipher_key = K_B;
    key_new_en = 1'b1;
    rk_rd_idx  = 4'd1;
    @(negedge clk);
    key_new_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_rd", rk_rd_data, m_rk[1]);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ready", 128'(key_ready), 128'(0));
    chk("async_rst_busy", 128'(key_busy), 128'(0));
    chk("async_rst_valid", 128'(rk_valid), 128'(0));
    chk("async_rst_rd", rk_rd_data, 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tb_rk10 = '0;
    rd(4'd1, d);
    chk("post_rst_rk1", d, 128'(0));
    chk("post_rst_ready", 128'(key_ready), 128'(0));
    chk("post_rst_valid", 128'(rk_valid), 128'(0));

    // fresh expansion after reset
    run_expansion(K_A, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
